// File: rtl/count_seg_scan.sv
// count_seg_scan
//   Display stage for a 4-bit binary counter. Snapshots the counter value,
//   splits it into two BCD digits and scans them onto a 2-digit common-anode
//   7-segment display. Blank dead-time gaps between digits prevent ghosting.
//   A one-cycle frame strobe marks the start of each scan frame.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   count[3:0] in   counter value to display
//   load       in   capture count (takes effect at the next frame boundary)
//   seg[6:0]   out  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   an[1:0]    out  digit enables, an[0] = ones, an[1] = tens
//   frame_stb  out  one-cycle pulse with the first ones-digit output cycle
//
// Parameters
//   SCAN_DIV     cycles each digit is driven (1..255)
//   DEAD         blank cycles between digits (0..15, 0 = no gap states)
//   SEG_ACT_LOW  1: seg/an active-low, 0: active-high
//
// Configuration macro
//   SEG_BLANK_LZ_EN  when defined, a zero tens digit is blanked (" 7" not "07")

module count_seg_scan #(
    parameter int unsigned SCAN_DIV    = 4,
    parameter int unsigned DEAD        = 1,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_stb
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIGIT_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST   = DIV_W'((DEAD == 0) ? 0 : DEAD - 1);
    localparam bit               HAS_GAP    = (DEAD != 0);
    localparam logic [6:0]       SEG_OFF    = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]       AN_OFF     = SEG_ACT_LOW ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_GAP1 = 2'd1,
        S_TENS = 2'd2,
        S_GAP0 = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             last;
    logic             frame_enter;

    logic [3:0]       hold;
    logic [3:0]       snap;
    logic             pend;

    logic             tens;
    logic [3:0]       ones;

    logic [6:0]       seg_nxt;
    logic [1:0]       an_nxt;
    logic             stb_nxt;

    // Segment pattern, active-high, gfedcba
    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // State register and per-state cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_ONES;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= last ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Next-state logic; gap states are bypassed when DEAD is zero
    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        case (state)
            S_ONES, S_TENS: last = (div_cnt == DIGIT_LAST);
            default:        last = (div_cnt == GAP_LAST);
        endcase
        if (last) begin
            case (state)
                S_ONES:  state_nxt = HAS_GAP ? S_GAP1 : S_TENS;
                S_GAP1:  state_nxt = S_TENS;
                S_TENS:  state_nxt = HAS_GAP ? S_GAP0 : S_ONES;
                default: state_nxt = S_ONES;
            endcase
        end
        frame_enter = last && (state_nxt == S_ONES);
    end

    // Capture: loads park in hold and transfer to snap only at a frame boundary,
    // so both digits of a frame always come from the same value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            snap <= '0;
            pend <= 1'b0;
        end else if (frame_enter) begin
            if (load) begin
                hold <= count;
                snap <= count;
                pend <= 1'b0;
            end else if (pend) begin
                snap <= hold;
                pend <= 1'b0;
            end
        end else if (load) begin
            hold <= count;
            pend <= 1'b1;
        end
    end

    // Binary to BCD, input range 0..15
    always_comb begin
        tens = (snap >= 4'd10);
        ones = tens ? (snap - 4'd10) : snap;
    end

    // Output decode (active-high internally, polarity applied at the end)
    always_comb begin
        logic [6:0] seg_on;
        logic [1:0] an_on;
        seg_on  = 7'h00;
        an_on   = 2'b00;
        stb_nxt = (state == S_ONES) && (div_cnt == '0);
        case (state)
            S_ONES: begin
                an_on  = 2'b01;
                seg_on = font(ones);
            end
            S_TENS: begin
`ifdef SEG_BLANK_LZ_EN
                if (tens) begin
                    an_on  = 2'b10;
                    seg_on = font({3'b000, tens});
                end
`else
                an_on  = 2'b10;
                seg_on = font({3'b000, tens});
`endif
            end
            default: begin
                an_on  = 2'b00;
                seg_on = 7'h00;
            end
        endcase
        seg_nxt = SEG_ACT_LOW ? ~seg_on : seg_on;
        an_nxt  = SEG_ACT_LOW ? ~an_on  : an_on;
    end

    // Output registers; reset blanks the display immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= SEG_OFF;
            an        <= AN_OFF;
            frame_stb <= 1'b0;
        end else begin
            seg       <= seg_nxt;
            an        <= an_nxt;
            frame_stb <= stb_nxt;
        end
    end

endmodule

// File: tb/tb_count_seg_scan.sv
// tb_count_seg_scan
//   Scoreboard bench for count_seg_scan. Expected display cycles are built
//   from the font table and frame timing, queued, and popped one per clock.
//   dut  : SCAN_DIV=4, DEAD=1, active-low
//   dut2 : SCAN_DIV=1, DEAD=0, active-low, permanently loading 12

module tb_count_seg_scan;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       stb;
    } exp_t;

`ifdef SEG_BLANK_LZ_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] count;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_stb;

    logic [3:0] count2;
    logic       load2;
    logic [6:0] seg2;
    logic [1:0] an2;
    logic       frame_stb2;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    count_seg_scan #(.SCAN_DIV(4), .DEAD(1), .SEG_ACT_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .count(count), .load(load),
        .seg(seg), .an(an), .frame_stb(frame_stb)
    );

    count_seg_scan #(.SCAN_DIV(1), .DEAD(0), .SEG_ACT_LOW(1'b1)) dut2 (
        .clk(clk), .rst(rst), .count(count2), .load(load2),
        .seg(seg2), .an(an2), .frame_stb(frame_stb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] font_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Queue one 10-cycle frame of value v for dut, dropping the first 'skip' cycles
    function automatic void push_frame(input int v, input int skip);
        exp_t e;
        exp_t f[10];
        int   t;
        int   o;
        t = (v >= 10) ? 1 : 0;
        o = v - 10 * t;
        for (int i = 0; i < 10; i++) begin
            e.an = 2'b11; e.seg = 7'h7F; e.stb = 1'b0;
            if (i < 4) begin
                e.an = 2'b10; e.seg = ~font_of(o); e.stb = (i == 0);
            end else if (i >= 5 && i < 9 && !(LZ && t == 0)) begin
                e.an = 2'b01; e.seg = ~font_of(t);
            end
            f[i] = e;
        end
        for (int i = skip; i < 10; i++) sb.push_back(f[i]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; count = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({an, seg, frame_stb} !== {2'b11, 7'h7F, 1'b0}) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: an=%b seg=%h stb=%b, expected an=11 seg=7f stb=0",
                         i, an, seg, frame_stb);
            end
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({an, seg, frame_stb} !== {2'b10, 7'h40, 1'b1}) begin
            n_err++;
            $display("FAIL reset_release: an=%b seg=%h stb=%b, expected an=10 seg=40 stb=1",
                     an, seg, frame_stb);
        end
    endtask

    // Load 13 mid-frame: rest of frame shows 0, next frame shows 13
    task automatic test_frame();
        int   n;
        exp_t e;
        push_frame(0, 1);
        push_frame(13, 0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            load  = (i == 0);
            count = 4'd13;
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({an, seg, frame_stb} !== {e.an, e.seg, e.stb}) begin
                n_err++;
                $display("FAIL frame13[%0d]: an=%b seg=%h stb=%b, expected an=%b seg=%h stb=%b",
                         i, an, seg, frame_stb, e.an, e.seg, e.stb);
            end
        end
        load = 1'b0;
    endtask

    // Load 5 during S_ONES: current frame keeps 13, next frame shows 5
    task automatic test_mid_load();
        int   n;
        exp_t e;
        push_frame(13, 0);
        push_frame(5, 0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            load  = (i == 1);
            count = 4'd5;
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({an, seg, frame_stb} !== {e.an, e.seg, e.stb}) begin
                n_err++;
                $display("FAIL mid_load[%0d]: an=%b seg=%h stb=%b, expected an=%b seg=%h stb=%b",
                         i, an, seg, frame_stb, e.an, e.seg, e.stb);
            end
        end
        load = 1'b0;
    endtask

    // Boundary load of 9 shows at once; then 15 and 2 in one frame, 2 wins
    task automatic test_back_to_back();
        int   n;
        exp_t e;
        push_frame(5, 0);
        push_frame(9, 0);
        push_frame(2, 0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            load = 1'b0;
            count = 4'd0;
            if (i == 9)  begin load = 1'b1; count = 4'd9;  end
            if (i == 12) begin load = 1'b1; count = 4'd15; end
            if (i == 15) begin load = 1'b1; count = 4'd2;  end
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({an, seg, frame_stb} !== {e.an, e.seg, e.stb}) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: an=%b seg=%h stb=%b, expected an=%b seg=%h stb=%b",
                         i, an, seg, frame_stb, e.an, e.seg, e.stb);
            end
        end
        load = 1'b0;
    endtask

    // Reset mid-S_TENS blanks asynchronously; scan restarts showing 0
    task automatic test_mid_reset();
        int   n;
        exp_t e;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({an, seg, frame_stb} !== {2'b11, 7'h7F, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: an=%b seg=%h stb=%b, expected an=11 seg=7f stb=0",
                     an, seg, frame_stb);
        end
        tick();
        tick();
        rst = 1'b0;
        push_frame(0, 0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({an, seg, frame_stb} !== {e.an, e.seg, e.stb}) begin
                n_err++;
                $display("FAIL restart[%0d]: an=%b seg=%h stb=%b, expected an=%b seg=%h stb=%b",
                         i, an, seg, frame_stb, e.an, e.seg, e.stb);
            end
        end
    endtask

    // SCAN_DIV=1, DEAD=0: digits alternate every cycle, strobe every 2 cycles
    task automatic test_no_dead();
        exp_t e;
        int   waited;
        waited = 0;
        while (frame_stb2 !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        n_vec++;
        if (frame_stb2 !== 1'b1) begin
            n_err++;
            $display("FAIL no_dead_sync: stb=%b after %0d cycles, expected 1", frame_stb2, waited);
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (i % 2 == 0) begin
                    e.an = 2'b10; e.seg = ~font_of(2); e.stb = 1'b1;
                end else begin
                    e.an = 2'b01; e.seg = ~font_of(1); e.stb = 1'b0;
                end
                sb.push_back(e);
            end
            for (int i = 0; i < 10; i++) begin
                if (i > 0) tick();
                e = sb.pop_front();
                n_vec++;
                if ({an2, seg2, frame_stb2} !== {e.an, e.seg, e.stb}) begin
                    n_err++;
                    $display("FAIL no_dead[%0d]: an=%b seg=%h stb=%b, expected an=%b seg=%h stb=%b",
                             i, an2, seg2, frame_stb2, e.an, e.seg, e.stb);
                end
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        load   = 1'b0;
        count  = 4'd0;
        load2  = 1'b1;
        count2 = 4'd12;
        test_reset();
        test_frame();
        test_mid_load();
        test_back_to_back();
        test_mid_reset();
        test_no_dead();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
